// File: rtl/seq_div_32bit_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_div_32bit_pkg;

    // Divider control states; operand capture happens on the start edge from any state.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_EXC  = 2'd3
    } div_state_e;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    // True when the signed quotient is undefined or unrepresentable.
    function automatic logic div_is_exc(input logic [31:0] a, input logic [31:0] b);
        return (b == '0) || ((a == INT_MIN) && (b == NEG_ONE));
    endfunction

endpackage

// File: rtl/seq_div_32bit_trial_sub.sv
// Trial subtractor: d = a - b computed as a + ~b + 1 on a parallel-prefix
// carry-lookahead adder. borrow is the inverted carry-out.
import seq_div_32bit_pkg::*;

module div_trial_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         borrow
);
    localparam int LV = $clog2(W);

    logic [W-1:0] bn;
    logic [W-1:0] g, p, gn, pn, p0;
    logic [W:0]   c;

    assign bn = ~b;

    // Kogge-Stone prefix over generate/propagate; carry-in is fixed at 1.
    always_comb begin
        g  = a & bn;
        p  = a ^ bn;
        p0 = p;
        gn = '0;
        pn = '0;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < W; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        // Carry into bit i+1 is G[i:0] | P[i:0] & cin, with cin = 1.
        c      = {g | p, 1'b1};
        d      = p0 ^ c[W-1:0];
        borrow = ~c[W];
    end

endmodule

// File: rtl/seq_div_32bit.sv
// Multi-cycle signed restoring divider: one trial subtraction per cycle,
// quotient truncated toward zero, divide-by-zero / overflow flagged.
import seq_div_32bit_pkg::*;

module seq_div_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rs, diff;
    logic             borrow;

    // Magnitudes as unsigned; INT_MIN maps to itself, which is correct unsigned.
    assign a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Shift the next dividend bit into the partial remainder.
    assign rs = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_sub (
        .a      (rs),
        .b      ({1'b0, b_q}),
        .d      (diff),
        .borrow (borrow)
    );

    // Next-state, datapath and output logic; a start pulse preempts any state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        r_d      = r_q;
        q_d      = q_q;
        b_d      = b_q;
        sign_d   = sign_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (ctrl_div) begin
            b_d     = b_abs;
            q_d     = a_abs;
            r_d     = '0;
            count_d = '0;
            sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            exc_d   = 1'b0;
            state_d = div_is_exc(data_operandA, data_operandB) ? DIV_EXC : DIV_ITER;
        end else begin
            case (state_q)
                DIV_ITER: begin
                    // Partial remainder stays below |B| <= 2^31, so borrow equals diff's sign.
                    r_d     = borrow ? rs : diff;
                    q_d     = {q_q[WIDTH-2:0], ~borrow};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) state_d = DIV_FIX;
                end
                DIV_FIX: begin
                    result_d = sign_q ? -q_q : q_q;
                    exc_d    = 1'b0;
                    rdy_d    = 1'b1;
                    state_d  = DIV_IDLE;
                end
                DIV_EXC: begin
                    result_d = '0;
                    exc_d    = 1'b1;
                    rdy_d    = 1'b1;
                    state_d  = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= DIV_IDLE;
            count_q  <= '0;
            r_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            r_q      <= r_d;
            q_q      <= q_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_div_32bit.sv
// Bench for seq_div_32bit: directed literal cases plus randomized traffic,
// all checked each cycle against a countdown-based behavioural model.
module tb_seq_div_32bit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_div;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_tests = 0;
    int n_fail  = 0;

    seq_div_32bit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference quotient from plain signed arithmetic.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic exc);
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            res = $signed(a) / $signed(b);
            exc = 1'b0;
        end
    endtask

    // Behavioural model: each accepted start arms a countdown of 33 (or 1 for exceptions).
    logic        m_pend = 1'b0;
    int          m_k, m_lat;
    logic [31:0] m_res_p;
    logic        m_exc_p;
    logic        exp_rdy = 1'b0, exp_exc = 1'b0, res_known = 1'b0;
    logic [31:0] exp_res = 32'd0;
    logic        chk_en = 1'b0;

    always @(posedge clock) begin
        exp_rdy = 1'b0;
        if (reset) begin
            m_pend    = 1'b0;
            exp_res   = 32'd0;
            exp_exc   = 1'b0;
            res_known = 1'b1;
        end else if (ctrl_div) begin
            ref_div(data_operandA, data_operandB, m_res_p, m_exc_p);
            m_pend    = 1'b1;
            m_k       = 0;
            m_lat     = m_exc_p ? 1 : 33;
            exp_exc   = 1'b0;
            res_known = 1'b0;
        end else if (m_pend) begin
            m_k++;
            if (m_k == m_lat) begin
                m_pend    = 1'b0;
                exp_rdy   = 1'b1;
                exp_res   = m_res_p;
                exp_exc   = m_exc_p;
                res_known = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("rdy", {31'd0, data_resultRDY}, {31'd0, exp_rdy});
            chk("exception", {31'd0, data_exception}, {31'd0, exp_exc});
            if (res_known) chk("result", data_result, exp_res);
        end
    end

    // Caller sits on a negedge; the following posedge samples the start.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask

    // Observe n cycles; report RDY pulse count and cycle of the first pulse.
    task automatic watch(input int n, output int pulses, output int first_at);
        pulses   = 0;
        first_at = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
        end
    endtask

    // Directed op with literal expectations, then checks the hold after RDY drops.
    task automatic run_lit(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic ee, input int elat);
        int lat;
        lat = -1;
        start(a, b);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clock);
            if (data_resultRDY) lat = k;
        end
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_res"}, data_result, er);
        chk({nm, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
        @(negedge clock);
        chk({nm, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
        chk({nm, "_res_hold"}, data_result, er);
        chk({nm, "_exc_hold"}, {31'd0, data_exception}, {31'd0, ee});
    endtask

    initial begin
        int          p, f;
        logic [31:0] a, b;
        logic        seen;
        reset         = 1'b1;
        ctrl_div      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("reset_res", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);

        run_lit("t1_100_7",    32'd100,          32'd7,           32'd14,          1'b0, 33);
        run_lit("t2_m100_7",   -32'sd100,        32'd7,           32'hFFFF_FFF2,   1'b0, 33);
        run_lit("t2_100_m7",   32'd100,          -32'sd7,         32'hFFFF_FFF2,   1'b0, 33);
        run_lit("t2_m100_m7",  -32'sd100,        -32'sd7,         32'd14,          1'b0, 33);
        run_lit("t3_div0",     32'd7,            32'd0,           32'd0,           1'b1, 1);
        run_lit("t4_ovf",      32'h8000_0000,    32'hFFFF_FFFF,   32'd0,           1'b1, 1);
        run_lit("t4_min_2",    32'h8000_0000,    32'd2,           32'hC000_0000,   1'b0, 33);
        run_lit("t_small",     32'd3,            32'd5,           32'd0,           1'b0, 33);
        run_lit("t_max",       32'hFFFF_FFFF,    32'h8000_0000,   32'd0,           1'b0, 33);

        // Abort mid-iteration: only the second op completes.
        start(32'd1000, 32'd10);
        repeat (9) @(negedge clock);
        start(32'd9, 32'd3);
        watch(40, p, f);
        chk("t5_pulses", p, 1);
        chk("t5_lat", f, 33);
        chk("t5_res", data_result, 32'd3);

        // Restart on the completion edge suppresses the old RDY.
        start(32'd100, 32'd7);
        repeat (32) @(negedge clock);
        start(32'd20, 32'd4);
        watch(40, p, f);
        chk("fix_pulses", p, 1);
        chk("fix_lat", f, 33);
        chk("fix_res", data_result, 32'd5);

        // Reset mid-operation.
        start(32'd50, 32'd5);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        watch(40, p, f);
        chk("t6_pulses", p, 0);
        chk("t6_res", data_result, 32'd0);
        chk("t6_exc", {31'd0, data_exception}, 32'd0);
        run_lit("t6_6_4", 32'd6, 32'd4, 32'd1, 1'b0, 33);

        // Reset wins over a simultaneous start.
        reset         = 1'b1;
        ctrl_div      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(negedge clock);
        reset    = 1'b0;
        ctrl_div = 1'b0;
        watch(40, p, f);
        chk("rst_start_pulses", p, 0);

        // Back-to-back: new start in the RDY cycle.
        start(32'd30, 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            seen = data_resultRDY;
        end
        chk("b2b_first_rdy", {31'd0, seen}, 32'd1);
        start(-32'sd30, 32'd3);
        watch(40, p, f);
        chk("b2b_pulses", p, 1);
        chk("b2b_lat", f, 33);
        chk("b2b_res", data_result, 32'hFFFF_FFF6);

        // Randomized traffic with occasional aborts; the model checks every cycle.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'h8000_0000; b = $urandom >> $urandom_range(0, 31); end
                3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            if ($urandom_range(0, 1) == 1) b = -b;
            start(a, b);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 34)) @(negedge clock);
            end else begin
                for (int k = 0; k < 40 && !data_resultRDY; k++) @(negedge clock);
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
        repeat (40) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
